// File: rtl/prime_check_seq.sv
// prime_check_seq: sequential primality checker for N-bit unsigned operands.
// Trial-divides by 2, then by odd divisors 3, 5, 7, ... while d*d <= n, and
// reports the prime flag plus the smallest nontrivial factor. One operand is
// in flight at a time; valid/ready handshake on both sides.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   in_valid    source presents in_data
//   in_ready    operand accepted this cycle if in_valid (high only in IDLE)
//   in_data     operand n
//   out_valid   result valid, held until out_ready
//   out_ready   sink consumes the result
//   out_data    echo of the accepted operand
//   out_prime   1 = operand is prime
//   out_factor  smallest factor >= 2 if composite, else 0
//
// DW must be wide enough that d never wraps while d*d <= 2^N-1; the default
// N+1 leaves ample headroom since d stays below 2^(N/2+1).
module prime_check_seq #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = N + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_prime,
    output logic [N-1:0] out_factor
);

    localparam int unsigned SQW = 2 * DW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    n_q, n_d;
    logic [DW-1:0]   d_q, d_d;
    logic            valid_q, valid_d;
    logic            prime_q, prime_d;
    logic [N-1:0]    factor_q, factor_d;
    logic [N-1:0]    data_q, data_d;

    logic [SQW-1:0]  d_sq;
    logic [DW-1:0]   divisor;
    logic [DW-1:0]   rem;

    // Square at double width so the termination compare never truncates.
    assign d_sq    = SQW'(d_q) * SQW'(d_q);
    // d is only zero outside CHECK; avoid a divide-by-zero there.
    assign divisor = (d_q == DW'(0)) ? DW'(1) : d_q;
    assign rem     = DW'(n_q) % divisor;

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_prime  = prime_q;
    assign out_factor = factor_q;

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            d_q      <= '0;
            valid_q  <= 1'b0;
            prime_q  <= 1'b0;
            factor_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            d_q      <= d_d;
            valid_q  <= valid_d;
            prime_q  <= prime_d;
            factor_q <= factor_d;
            data_q   <= data_d;
        end
    end

    // Next-state and result logic.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        d_d      = d_q;
        valid_d  = valid_q;
        prime_d  = prime_q;
        factor_d = factor_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    n_d    = in_data;
                    data_d = in_data;
                    if (in_data < N'(2)) begin
                        prime_d  = 1'b0;
                        factor_d = '0;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else if ((in_data == N'(2)) || (in_data == N'(3))) begin
                        prime_d  = 1'b1;
                        factor_d = '0;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else if (!in_data[0]) begin
                        prime_d  = 1'b0;
                        factor_d = N'(2);
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        d_d     = DW'(3);
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (d_sq > SQW'(n_q)) begin
                    prime_d  = 1'b1;
                    factor_d = '0;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (rem == DW'(0)) begin
                    prime_d  = 1'b0;
                    factor_d = N'(d_q);
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    d_d = d_q + DW'(2);
                end
            end

            S_DONE: begin
                // Consume returns to IDLE; accept waits for the next cycle.
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prime_check_seq.sv
// Testbench for prime_check_seq: three instances (N=8, 4, 12) checked against
// a trial-division reference model for result and latency.
module tb_prime_check_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic        iv8, iv4, iv12;
    logic        or8, or4, or12;

    logic        ir8, ov8, op8;
    logic [7:0]  od8, of8;
    logic        ir4, ov4, op4;
    logic [3:0]  od4, of4;
    logic        ir12, ov12, op12;
    logic [11:0] od12, of12;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic        s_ir, s_ov, s_op;
    logic [11:0] s_od, s_of;

    always #5 clk = ~clk;

    prime_check_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(din[7:0]),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_prime(op8), .out_factor(of8)
    );

    prime_check_seq #(.N(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(din[3:0]),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_prime(op4), .out_factor(of4)
    );

    prime_check_seq #(.N(12)) u12 (
        .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .in_data(din),
        .out_valid(ov12), .out_ready(or12), .out_data(od12), .out_prime(op12), .out_factor(of12)
    );

    // View of the instance currently under test.
    always_comb begin
        s_ir = 1'b0; s_ov = 1'b0; s_op = 1'b0; s_od = '0; s_of = '0;
        case (sel)
            0: begin s_ir = ir8;  s_ov = ov8;  s_op = op8;  s_od = 12'(od8);  s_of = 12'(of8);  end
            1: begin s_ir = ir4;  s_ov = ov4;  s_op = op4;  s_od = 12'(od4);  s_of = 12'(of4);  end
            default: begin s_ir = ir12; s_ov = ov12; s_op = op12; s_od = od12; s_of = of12; end
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 4 : 12;
    endfunction

    // Reference: smallest divisor by plain trial division; latency from the
    // count of odd trial divisors the algorithm has to look at.
    function automatic void golden(input int n, output bit p, output int f, output int lat);
        int c;
        p = 1'b0;
        f = 0;
        if (n >= 2) begin
            for (int k = 2; k * k <= n; k++) begin
                if (n % k == 0) begin
                    f = k;
                    break;
                end
            end
            p = (f == 0);
        end
        if (n < 4 || n % 2 == 0) begin
            lat = 1;
        end else begin
            if (p) begin
                c = 1;
                for (int d = 3; d * d <= n; d += 2) c++;
            end else begin
                c = (f - 1) / 2;
            end
            lat = 1 + c;
        end
    endfunction

    task automatic set_iv(input bit v);
        case (sel)
            0: iv8 = v;
            1: iv4 = v;
            default: iv12 = v;
        endcase
    endtask

    task automatic set_or(input bit v);
        case (sel)
            0: or8 = v;
            1: or4 = v;
            default: or12 = v;
        endcase
    endtask

    // One complete transaction with optional backpressure on the sink side.
    task automatic do_op(input int n, input int stall, input bit check_lat);
        bit ep;
        int ef, el, lat;
        string tag;
        tag = $sformatf("N%0d n=%0d", width_of(sel), n);
        golden(n, ep, ef, el);

        @(negedge clk);
        checks++;
        if (s_ir !== 1'b1) begin errors++; $display("FAIL %s in_ready before accept: got %b expected 1", tag, s_ir); end
        din = 12'(n);
        set_or(1'b0);
        set_iv(1'b1);
        @(posedge clk);
        #1 set_iv(1'b0);

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (s_ov !== 1'b1 && lat < 100);

        checks++;
        if (s_ov !== 1'b1) begin
            errors++; $display("FAIL %s out_valid timeout: got %b expected 1", tag, s_ov);
        end else begin
            if (check_lat) begin
                checks++;
                if (lat != el) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, el); end
            end
            checks++;
            if (s_op !== ep) begin errors++; $display("FAIL %s prime: got %b expected %b", tag, s_op, ep); end
            checks++;
            if (s_of !== 12'(ef)) begin errors++; $display("FAIL %s factor: got %0d expected %0d", tag, s_of, ef); end
            checks++;
            if (s_od !== 12'(n)) begin errors++; $display("FAIL %s data: got %0d expected %0d", tag, s_od, n); end
        end

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if ({s_ov, s_ir, s_op, s_od, s_of} !== {1'b1, 1'b0, ep, 12'(n), 12'(ef)}) begin
                errors++;
                $display("FAIL %s stall hold: got v%b r%b p%b d%0d f%0d expected v1 r0 p%b d%0d f%0d",
                         tag, s_ov, s_ir, s_op, s_od, s_of, ep, n, ef);
            end
        end

        set_or(1'b1);
        @(posedge clk);
        #1 set_or(1'b0);
        @(negedge clk);
        checks++;
        if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
            errors++; $display("FAIL %s release: got valid %b ready %b expected valid 0 ready 1", tag, s_ov, s_ir);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            checks++;
            if ({s_ir, s_ov, s_op, s_od, s_of} !== {1'b1, 1'b0, 1'b0, 12'd0, 12'd0}) begin
                errors++;
                $display("FAIL reset N%0d: got r%b v%b p%b d%0d f%0d expected r1 v0 p0 d0 f0",
                         width_of(s), s_ir, s_ov, s_op, s_od, s_of);
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_check();
        sel = 0;
        @(negedge clk);
        din = 12'd251;
        set_iv(1'b1);
        @(posedge clk);
        #1 set_iv(1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (s_ov !== 1'b0 || s_ir !== 1'b0) begin
            errors++; $display("FAIL midcheck busy: got valid %b ready %b expected valid 0 ready 0", s_ov, s_ir);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ir, s_ov, s_op, s_od, s_of} !== {1'b1, 1'b0, 1'b0, 12'd0, 12'd0}) begin
            errors++;
            $display("FAIL midcheck reset: got r%b v%b p%b d%0d f%0d expected r1 v0 p0 d0 f0",
                     s_ir, s_ov, s_op, s_od, s_of);
        end
    endtask

    task automatic test_trivial();
        sel = 0;
        for (int n = 0; n <= 4; n++) do_op(n, 0, 1'b1);
    endtask

    task automatic test_small_odd();
        sel = 0;
        do_op(9, 0, 1'b1);
        do_op(25, 0, 1'b1);
        do_op(5, 0, 1'b1);
    endtask

    task automatic test_worst_case();
        sel = 0;
        do_op(251, 0, 1'b1);
        do_op(255, 0, 1'b1);
        do_op(221, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        sel = 0;
        @(negedge clk);
        din = 12'd7;
        set_or(1'b0);
        set_iv(1'b1);
        @(posedge clk);
        #1 set_iv(1'b0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (s_ov !== 1'b1 && lat < 100);
        checks++;
        if (s_ov !== 1'b1 || lat != 2) begin
            errors++; $display("FAIL bp result: got valid %b latency %0d expected valid 1 latency 2", s_ov, lat);
        end
        // Offer a competing operand throughout the stall.
        din = 12'd100;
        set_iv(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({s_ov, s_ir, s_op, s_od, s_of} !== {1'b1, 1'b0, 1'b1, 12'd7, 12'd0}) begin
                errors++;
                $display("FAIL bp stall %0d: got v%b r%b p%b d%0d f%0d expected v1 r0 p1 d7 f0",
                         i, s_ov, s_ir, s_op, s_od, s_of);
            end
        end
        set_or(1'b1);
        @(posedge clk);
        #1;
        set_or(1'b0);
        set_iv(1'b0);
        @(negedge clk);
        checks++;
        if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
            errors++; $display("FAIL bp bubble: got valid %b ready %b expected valid 0 ready 1", s_ov, s_ir);
        end
        @(negedge clk);
        checks++;
        if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
            errors++; $display("FAIL bp no accept: got valid %b ready %b expected valid 0 ready 1", s_ov, s_ir);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 2));
            do_op(int'($urandom_range(0, (1 << width_of(sel)) - 1)), int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int n = 0; n < (1 << width_of(s)); n++) do_op(n, 0, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        iv8 = 1'b0; iv4 = 1'b0; iv12 = 1'b0;
        or8 = 1'b0; or4 = 1'b0; or12 = 1'b0;
        test_reset();
        test_reset_mid_check();
        test_trivial();
        test_small_odd();
        test_worst_case();
        test_backpressure();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
